// File: rtl/serial_receiver_32_w.sv
// serial_receiver_32_w: 8N1 frame receiver that reassembles n_word 16-bit words and checks a Modbus CRC-16 trailer
module serial_receiver_32_w #(
  parameter int n_word = 32,
  parameter int bit_period = 4,
  parameter int idle_gap = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [15:0] data_0,
  output logic [15:0] data_1,
  output logic [15:0] data_2,
  output logic [15:0] data_3,
  output logic [15:0] data_4,
  output logic [15:0] data_5,
  output logic [15:0] data_6,
  output logic [15:0] data_7,
  output logic [15:0] data_8,
  output logic [15:0] data_9,
  output logic [15:0] data_10,
  output logic [15:0] data_11,
  output logic [15:0] data_12,
  output logic [15:0] data_13,
  output logic [15:0] data_14,
  output logic [15:0] data_15,
  output logic [15:0] data_16,
  output logic [15:0] data_17,
  output logic [15:0] data_18,
  output logic [15:0] data_19,
  output logic [15:0] data_20,
  output logic [15:0] data_21,
  output logic [15:0] data_22,
  output logic [15:0] data_23,
  output logic [15:0] data_24,
  output logic [15:0] data_25,
  output logic [15:0] data_26,
  output logic [15:0] data_27,
  output logic [15:0] data_28,
  output logic [15:0] data_29,
  output logic [15:0] data_30,
  output logic [15:0] data_31,
  output logic        data_valid,
  output logic        crc_err,
  output logic        busy
);
  localparam int gap_clks = idle_gap * bit_period;
  localparam int cw = $clog2(bit_period);
  localparam int gw = $clog2(gap_clks + 1);

  typedef enum logic [1:0] {s_idle, s_start, s_data, s_stop} state_t;

  state_t state, state_nx;
  logic rx_m, rx_s, rx_d, armed, err, end1, ok1, end2, ok2;
  logic [cw-1:0] cnt;
  logic [2:0] bits;
  logic [7:0] sh, crc_sh, crc_lo;
  logic [gw-1:0] gap_cnt;
  logic [6:0] idx;
  logic [15:0] crc, crc_nx;
  logic [3:0] crc_left;
  logic [15:0] shadow [32];
  logic [15:0] words [32];
  logic fall, tick, start_ok, byte_end, gap_hit;

  assign fall = armed && rx_d && !rx_s;
  assign tick = (cnt == '0);
  assign start_ok = (state == s_start) && tick && !rx_s;
  assign byte_end = (state == s_stop) && tick;
  // gap only accumulates while no byte is in flight, so long runs of 1-bits inside a byte never count
  assign gap_hit = (state == s_idle) && rx_s && (idx != '0) && (gap_cnt == gw'(gap_clks - 1)) && !fall;
  assign crc_nx = (crc >> 1) ^ ((crc[0] ^ crc_sh[0]) ? 16'hA001 : 16'h0000);

  always_comb begin
    state_nx = state;
    unique case (state)
      s_idle:  state_nx = fall ? s_start : s_idle;
      s_start: state_nx = tick ? (rx_s ? s_idle : s_data) : s_start;
      s_data:  state_nx = (tick && bits == 3'd7) ? s_stop : s_data;
      s_stop:  state_nx = tick ? s_idle : s_stop;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b0;
      rx_s <= 1'b0;
      rx_d <= 1'b0;
      state <= s_idle;
      cnt <= '0;
      bits <= '0;
      sh <= '0;
      gap_cnt <= '0;
      armed <= 1'b0;
      idx <= '0;
      crc <= 16'hFFFF;
      crc_sh <= '0;
      crc_left <= '0;
      crc_lo <= '0;
      err <= 1'b0;
      end1 <= 1'b0;
      ok1 <= 1'b0;
      end2 <= 1'b0;
      ok2 <= 1'b0;
      data_valid <= 1'b0;
      crc_err <= 1'b0;
      busy <= 1'b0;
      shadow <= '{default: '0};
      words <= '{default: '0};
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
      state <= state_nx;
      cnt <= (state == s_idle) ? cw'(bit_period / 2 - 1) : tick ? cw'(bit_period - 1) : cnt - 1'b1;
      bits <= (state == s_data) ? (tick ? bits + 3'd1 : bits) : 3'd0;
      if (state == s_data && tick) sh <= {rx_s, sh[7:1]};
      gap_cnt <= (state == s_idle && rx_s) ? ((gap_cnt == gw'(gap_clks - 1)) ? gap_cnt : gap_cnt + 1'b1) : '0;
      armed <= armed | (state == s_idle && rx_s && gap_cnt >= gw'(bit_period - 1));
      end1 <= 1'b0;
      if (crc_left != '0) begin
        crc <= crc_nx;
        crc_sh <= crc_sh >> 1;
        crc_left <= crc_left - 1'b1;
      end
      if (start_ok && idx == '0) busy <= 1'b1;
      if (byte_end) begin
        if (idx < 7'(2 * n_word)) begin
          if (idx[0]) shadow[idx[5:1]][7:0] <= sh;
          else shadow[idx[5:1]][15:8] <= sh;
          crc_sh <= sh;
          crc_left <= 4'd8;
        end
        if (!rx_s) err <= 1'b1;
        if (idx == 7'(2 * n_word)) crc_lo <= sh;
        if (idx == 7'(2 * n_word + 1)) begin
          end1 <= 1'b1;
          ok1 <= (crc == {sh, crc_lo}) && !err && rx_s;
          idx <= '0;
          crc <= 16'hFFFF;
          err <= 1'b0;
        end else begin
          idx <= idx + 7'd1;
        end
      end
      if (gap_hit) begin
        idx <= '0;
        crc <= 16'hFFFF;
        crc_left <= '0;
        err <= 1'b0;
      end
      end2 <= end1;
      ok2 <= ok1;
      data_valid <= end2 && ok2;
      crc_err <= (end2 && !ok2) || gap_hit;
      if (end2 && ok2) words <= shadow;
      if (end2 || gap_hit) busy <= 1'b0;
    end
  end

  assign data_0 = words[0];
  assign data_1 = words[1];
  assign data_2 = words[2];
  assign data_3 = words[3];
  assign data_4 = words[4];
  assign data_5 = words[5];
  assign data_6 = words[6];
  assign data_7 = words[7];
  assign data_8 = words[8];
  assign data_9 = words[9];
  assign data_10 = words[10];
  assign data_11 = words[11];
  assign data_12 = words[12];
  assign data_13 = words[13];
  assign data_14 = words[14];
  assign data_15 = words[15];
  assign data_16 = words[16];
  assign data_17 = words[17];
  assign data_18 = words[18];
  assign data_19 = words[19];
  assign data_20 = words[20];
  assign data_21 = words[21];
  assign data_22 = words[22];
  assign data_23 = words[23];
  assign data_24 = words[24];
  assign data_25 = words[25];
  assign data_26 = words[26];
  assign data_27 = words[27];
  assign data_28 = words[28];
  assign data_29 = words[29];
  assign data_30 = words[30];
  assign data_31 = words[31];
endmodule

// File: tb/tb_serial_receiver_32_w.sv
// tb_serial_receiver_32_w: directed + random frame stimulus against a byte-level CRC/word reference model
module tb_serial_receiver_32_w;
  localparam int bp = 4;
  localparam int nw = 3;
  localparam int gap = 8;
  // sync (2) + edge detect (1) + start-to-stop-middle + 2-clk output pipe
  localparam int lat = 2 + 1 + bp / 2 + 9 * bp + 2;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0, reset, rx;
  logic [15:0] dout [32];
  logic data_valid, crc_err, busy;
  logic [15:0] model [32];
  logic [15:0] cand [32];
  bq_t fr;
  int cyc = 0, start_cyc = 0;
  int dv_n = 0, er_n = 0, dv_cyc = -1, er_cyc = -1;
  int tests = 0, fails = 0;
  int dv0, er0;

  serial_receiver_32_w #(.n_word(nw), .bit_period(bp), .idle_gap(gap)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .data_0(dout[0]), .data_1(dout[1]), .data_2(dout[2]), .data_3(dout[3]),
    .data_4(dout[4]), .data_5(dout[5]), .data_6(dout[6]), .data_7(dout[7]),
    .data_8(dout[8]), .data_9(dout[9]), .data_10(dout[10]), .data_11(dout[11]),
    .data_12(dout[12]), .data_13(dout[13]), .data_14(dout[14]), .data_15(dout[15]),
    .data_16(dout[16]), .data_17(dout[17]), .data_18(dout[18]), .data_19(dout[19]),
    .data_20(dout[20]), .data_21(dout[21]), .data_22(dout[22]), .data_23(dout[23]),
    .data_24(dout[24]), .data_25(dout[25]), .data_26(dout[26]), .data_27(dout[27]),
    .data_28(dout[28]), .data_29(dout[29]), .data_30(dout[30]), .data_31(dout[31]),
    .data_valid(data_valid), .crc_err(crc_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_n++;
      dv_cyc = cyc;
    end
    if (crc_err) begin
      er_n++;
      er_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(bp);
  endtask

  task automatic idle_bits(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_b, input int gap_bits);
    rx = 1'b0;
    start_cyc = cyc;
    tick(bp);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_b);
    idle_bits(gap_bits);
  endtask

  task automatic send_frame(input bq_t f, input int bad, input int nb);
    for (int i = 0; i < nb; i++) begin
      send_byte(f[i], i != bad, (i == bad) ? 1 : int'($urandom_range(0, 2)));
      if (i == 0) chk("busy_mid", 32'(busy), 32'd1);
    end
  endtask

  function automatic logic [15:0] crc16(input bq_t q);
    logic [15:0] c = 16'hFFFF;
    foreach (q[i]) begin
      c ^= {8'h00, q[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic rand_frame();
    logic [15:0] c;
    fr.delete();
    for (int k = 0; k < 32; k++) cand[k] = 16'h0000;
    for (int k = 0; k < nw; k++) begin
      cand[k] = 16'($urandom);
      fr.push_back(cand[k][15:8]);
      fr.push_back(cand[k][7:0]);
    end
    c = crc16(fr);
    fr.push_back(c[7:0]);
    fr.push_back(c[15:8]);
  endtask

  task automatic check_out(input string tag);
    for (int k = 0; k < 32; k++) chk($sformatf("%s_d%0d", tag, k), 32'(dout[k]), 32'(model[k]));
  endtask

  task automatic snap();
    dv0 = dv_n;
    er0 = er_n;
  endtask

  initial begin
    logic [63:0] golden;
    bq_t bad_fr;
    for (int k = 0; k < 32; k++) model[k] = 16'h0000;
    rx = 1'b1;
    reset = 1'b1;
    tick(4);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_err", 32'(crc_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    check_out("rst");
    reset = 1'b0;
    idle_bits(12);

    golden = 64'h0103_0000_000A_C5CD;
    fr.delete();
    for (int i = 0; i < 8; i++) fr.push_back(golden[63 - 8 * i -: 8]);
    snap();
    send_frame(fr, -1, 8);
    idle_bits(gap + 4);
    chk("gold_dv", 32'(dv_n - dv0), 32'd1);
    chk("gold_err", 32'(er_n - er0), 32'd0);
    chk("gold_lat", 32'(dv_cyc), 32'(start_cyc + lat));
    chk("gold_busy", 32'(busy), 32'd0);
    model[0] = 16'h0103;
    model[1] = 16'h0000;
    model[2] = 16'h000A;
    check_out("gold");

    bad_fr = fr;
    bad_fr[7] = 8'hCC;
    snap();
    send_frame(bad_fr, -1, 8);
    idle_bits(gap + 4);
    chk("crc_err_n", 32'(er_n - er0), 32'd1);
    chk("crc_dv_n", 32'(dv_n - dv0), 32'd0);
    chk("crc_lat", 32'(er_cyc), 32'(start_cyc + lat));
    check_out("crc_hold");

    rand_frame();
    snap();
    send_frame(fr, 2, 2 * nw + 2);
    idle_bits(gap + 4);
    chk("frm_err_n", 32'(er_n - er0), 32'd1);
    chk("frm_dv_n", 32'(dv_n - dv0), 32'd0);
    check_out("frm_hold");
    rand_frame();
    snap();
    send_frame(fr, -1, 2 * nw + 2);
    idle_bits(gap + 4);
    chk("frm_next_dv", 32'(dv_n - dv0), 32'd1);
    chk("frm_next_err", 32'(er_n - er0), 32'd0);
    model = cand;
    check_out("frm_next");

    rand_frame();
    snap();
    send_frame(fr, -1, 4);
    idle_bits(gap + 4);
    chk("trunc_err", 32'(er_n - er0), 32'd1);
    chk("trunc_dv", 32'(dv_n - dv0), 32'd0);
    chk("trunc_busy", 32'(busy), 32'd0);
    check_out("trunc_hold");
    rand_frame();
    snap();
    send_frame(fr, -1, 2 * nw + 2);
    idle_bits(gap + 4);
    chk("trunc_next_dv", 32'(dv_n - dv0), 32'd1);
    model = cand;
    check_out("trunc_next");

    rand_frame();
    send_byte(fr[0], 1'b1, 0);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rx = 1'b0;
    tick(bp);
    send_bit(fr[1][0]);
    send_bit(fr[1][1]);
    rx = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(3);
    for (int k = 0; k < 32; k++) model[k] = 16'h0000;
    chk("mid_rst_valid", 32'(data_valid), 32'd0);
    chk("mid_rst_err", 32'(crc_err), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    check_out("mid_rst");
    reset = 1'b0;
    snap();
    idle_bits(12);
    chk("post_rst_quiet", 32'(er_n - er0 + dv_n - dv0), 32'd0);
    rand_frame();
    send_frame(fr, -1, 2 * nw + 2);
    idle_bits(gap + 4);
    chk("post_rst_dv", 32'(dv_n - dv0), 32'd1);
    model = cand;
    check_out("post_rst");

    snap();
    rand_frame();
    send_frame(fr, -1, 2 * nw + 2);
    rx = 1'b1;
    tick(5 * bp);
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(5 * bp - 1);
    rand_frame();
    send_frame(fr, -1, 2 * nw + 2);
    idle_bits(gap + 4);
    chk("tput_dv", 32'(dv_n - dv0), 32'd2);
    chk("tput_err", 32'(er_n - er0), 32'd0);
    model = cand;
    check_out("tput");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_receiver_32_w.md
# serial_receiver_32_w

Receive-side counterpart of the 32-word serial transmitter: recovers UART-style frames from the `rx` line, reassembles `n_word` 16-bit words, and checks the CRC-16 (Modbus RTU) trailer. Only CRC-clean frames update the parallel word outputs, which feed the control/observer logic on the receiving FPGA. The block runs directly on the system clock and oversamples the line at `bit_period` clocks per bit, matching the transmitter's clk/4 bit rate.

## Interface
Parameters:
- `n_word`, 32: words per frame, 1..32. Outputs `data_k` with k ≥ `n_word` stay 0.
- `bit_period`, 4: clk cycles per serial bit, ≥ 4.
- `idle_gap`, 8: idle bit periods that end a frame and re-arm the byte index.

Ports:
- `clk`  in  1  system clock, the only clock.
- `reset`  in  1  synchronous, active-high.
- `rx`  in  1  serial line, asynchronous, idle high.
- `data_0` … `data_31`  out  16 each  last CRC-valid received words.
- `data_valid`  out  1  one-clk pulse when the outputs have just been updated.
- `crc_err`  out  1  one-clk pulse when a complete frame failed CRC or framing.
- `busy`  out  1  high from first start bit until end-of-frame handling.

## Operation
- **Line sync.** `rx` passes through 2 flip-flops. All logic uses the synchronized signal `rx_s`.
- **Byte format.** 8N1: start bit 0, 8 data bits LSB first, stop bit 1.
- **Frame layout.** `2*n_word` data bytes, then CRC low byte, then CRC high byte.
  - Each word is sent high byte first.
  - Bytes inside a frame are separated by ≤ 2 idle bits.
- **Bit FSM.**
  - IDLE: a falling edge of `rx_s` moves the FSM to START.
  - START: sample at bit middle (`bit_period/2` clocks after the edge). If `rx_s`=1, treat it as a glitch and return to IDLE.
  - DATA: 8 samples, spaced `bit_period` apart.
  - STOP: sample once. A 0 is a framing error.
  - Then return to IDLE.
- **Frame control.**
  - A byte index counts 0..`2*n_word`+1.
  - Data bytes go into shadow registers and into the CRC engine.
  - The CRC engine is bit-serial, 1 bit per clk, reflected polynomial 0xA001, init 0xFFFF. It finishes each byte well before the next byte arrives.
  - The two CRC bytes are captured and not fed to the engine.
- **Frame end**, at the STOP sample of byte `2*n_word`+1:
  - CRC match and no framing error in the frame: copy the shadow registers to `data_*` and pulse `data_valid`.
  - Otherwise: pulse `crc_err` and leave `data_*` unchanged.
  - In both cases, reset the index to 0 and the CRC to 0xFFFF.
- **Framing error mid-frame.** Set a sticky error flag. Keep counting bytes so that resynchronization stays on the idle gap.
- **Idle gap.** `rx_s` high for `idle_gap*bit_period` consecutive clocks while index ≠ 0:
  - discard the partial frame;
  - reset the index and CRC;
  - clear the error flag;
  - pulse `crc_err`.
- **Inter-frame gap.** The line is idle for ≥ `idle_gap`+2 bit periods between frames, so back-to-back frames never trip the gap logic mid-frame.

## Timing
- **Reset.** Every output is 0: `data_*`=0, `data_valid`=0, `crc_err`=0, `busy`=0. FSM is in IDLE, index=0, CRC=0xFFFF, error flag clear.
  - Reset mid-frame discards the frame and also clears `data_*`.
  - The first frame is accepted only after `rx_s` has been seen high for ≥ 1 bit period.
- **Input latency.** Synchronizer: 2 clk.
- **Sample point.** Start edge + `bit_period/2` + k·`bit_period`, for k = 0..9.
- **Output latency.** `data_*` and `data_valid` change on the 2nd clk edge after the final stop-bit sample. `data_valid` is high for exactly 1 clk. `crc_err` follows the same timing.
- **`busy`.**
  - Rises on the clk after the start-bit middle sample of byte 0.
  - Falls together with the `data_valid` or `crc_err` pulse.
  - Falls without a pulse on reset.
- **Simultaneous events.** Gap timeout and a falling edge on the same clk: the edge wins and the gap counter clears.
- **Outputs are stable** between `data_valid` pulses. Consumers may sample them at any time.

## Test plan
- **Reset.** Assert `reset` mid-byte, then release it → all outputs 0, and the next clean frame is received correctly.
- **Golden frame** (`n_word`=3). Bytes 01 03 00 00 00 0A C5 CD → `data_0`=0x0103, `data_1`=0x0000, `data_2`=0x000A. One `data_valid` pulse 2 clk after the last stop sample. `crc_err` stays 0.
- **Corrupted CRC.** Same frame with the last byte changed to CC → one `crc_err` pulse, `data_*` keep their previous values, no `data_valid`.
- **Framing error.** Force the stop bit of byte 2 to 0 → `crc_err` pulses at frame end. The following good frame updates the outputs.
- **Truncated frame.** Send 4 bytes, then hold idle for 8 bit periods → `crc_err` pulse, index re-armed. The next full frame is accepted.
- **Throughput.** Two back-to-back frames from the 32-word transmitter with a 10-bit gap, random data → two `data_valid` pulses, outputs equal the second frame's data, and a start glitch shorter than `bit_period/2` is ignored.
